// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uartRxState_t;

  function automatic int unsigned clocksPerBit(input int unsigned clockFrequency,
                                               input int unsigned baudRate);
    return clockFrequency / baudRate;
  endfunction

  function automatic int unsigned halfBit(input int unsigned clockFrequency,
                                          input int unsigned baudRate);
    return clocksPerBit(clockFrequency, baudRate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Free-running bit-period counter with synchronous clear; strobes at the
// half-bit and full-bit points measured from the last clear.
module uart_rx_bit_timer #(
  parameter int unsigned ClocksPerBit = 104,
  parameter int unsigned HalfBit      = 52
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic halfDone,
  output logic bitDone
);

  localparam int unsigned CountWidth = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
  localparam logic [CountWidth-1:0] HalfLast = CountWidth'(HalfBit - 1);
  localparam logic [CountWidth-1:0] BitLast  = CountWidth'(ClocksPerBit - 1);

  logic [CountWidth-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count + CountWidth'(1);
    end
  end

  assign halfDone = (count == HalfLast);
  assign bitDone  = (count == BitLast);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start-bit qualification at half bit,
// centre sampling of data and stop bits, break handling via WAIT_IDLE.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned BaudRate       = 9600,
  parameter int unsigned NrOfDataBits   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  output logic [NrOfDataBits-1:0] dataBits,
  output logic                    dataValid,
  output logic                    frameError,
  output logic                    busy
);

  localparam int unsigned ClocksPerBit  = clocksPerBit(ClockFrequency, BaudRate);
  localparam int unsigned HalfBit       = halfBit(ClockFrequency, BaudRate);
  localparam int unsigned BitCountWidth = $clog2(NrOfDataBits + 1);
  localparam logic [BitCountWidth-1:0] LastBit = BitCountWidth'(NrOfDataBits - 1);

  uartRxState_t            state, stateNext;
  logic                    rxMeta, rxSync;
  logic [BitCountWidth-1:0] bitCount, bitCountNext;
  logic [NrOfDataBits-1:0] shiftReg, shiftNext;
  logic                    clearTimer, halfDone, bitDone;
  logic                    validNext, errorNext, loadData;

  uart_rx_bit_timer #(
    .ClocksPerBit(ClocksPerBit),
    .HalfBit     (HalfBit)
  ) bitTimer (
    .clock   (clock),
    .reset   (reset),
    .clear   (clearTimer),
    .halfDone(halfDone),
    .bitDone (bitDone)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  always_comb begin
    stateNext    = state;
    bitCountNext = bitCount;
    shiftNext    = shiftReg;
    clearTimer   = 1'b0;
    validNext    = 1'b0;
    errorNext    = 1'b0;
    loadData     = 1'b0;
    case (state)
      IDLE: begin
        // Timer held cleared so the half-bit count starts at the detected edge.
        clearTimer = 1'b1;
        if (!rxSync) begin
          stateNext    = START;
          bitCountNext = '0;
        end
      end
      START: begin
        if (halfDone) begin
          clearTimer = 1'b1;
          stateNext  = rxSync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bitDone) begin
          clearTimer   = 1'b1;
          shiftNext    = {rxSync, shiftReg[NrOfDataBits-1:1]};
          bitCountNext = bitCount + BitCountWidth'(1);
          if (bitCount == LastBit) stateNext = STOP;
        end
      end
      STOP: begin
        if (bitDone) begin
          clearTimer = 1'b1;
          if (rxSync) begin
            loadData  = 1'b1;
            validNext = 1'b1;
            stateNext = IDLE;
          end else begin
            errorNext = 1'b1;
            stateNext = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        clearTimer = 1'b1;
        if (rxSync) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bitCount   <= '0;
      shiftReg   <= '0;
      dataBits   <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCount   <= bitCountNext;
      shiftReg   <= shiftNext;
      dataValid  <= validNext;
      frameError <= errorNext;
      if (loadData) dataBits <= shiftReg;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default timing (104 clocks per bit).
module tb_uart_rx;

  localparam int unsigned Cpb = 104;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] dataBits;
  logic       dataValid, frameError, busy;

  uart_rx #(
    .ClockFrequency(1000000),
    .BaudRate      (9600),
    .NrOfDataBits  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .dataBits  (dataBits),
    .dataValid (dataValid),
    .frameError(frameError),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       isError;
    logic [7:0] data;
  } expect_t;

  expect_t    expQ[$];
  expect_t    monExp;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] lastGood = 8'h00;

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && (dataValid || frameError)) begin
      checkEq("pulseExclusive", 32'(dataValid & frameError), 32'd0);
      if (expQ.size() == 0) begin
        checkEq("unexpectedPulse", 32'({dataValid, frameError}), 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkEq("pulseIsError", 32'(frameError), 32'(monExp.isError));
        checkEq("dataBits", 32'(dataBits), 32'(monExp.data));
      end
    end
  end

  task automatic holdRx(input logic level, input int unsigned cycles);
    rx = level;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int unsigned cpb);
    holdRx(1'b0, cpb);
    for (int i = 0; i < 8; i++) holdRx(data[i], cpb);
    holdRx(stopBit, cpb);
  endtask

  task automatic pushValid(input logic [7:0] data);
    expQ.push_back({1'b0, data});
    lastGood = data;
  endtask

  task automatic pushError();
    expQ.push_back({1'b1, lastGood});
  endtask

  initial begin
    logic [7:0] partial;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    checkEq("resetDataBits", 32'(dataBits), 32'd0);
    checkEq("resetDataValid", 32'(dataValid), 32'd0);
    checkEq("resetFrameError", 32'(frameError), 32'd0);
    checkEq("resetBusy", 32'(busy), 32'd0);
    reset = 1'b0;
    holdRx(1'b1, 5);

    // Single valid frame
    pushValid(8'hA5);
    sendFrame(8'hA5, 1'b1, Cpb);
    holdRx(1'b1, 20);
    checkEq("busyAfterA5", 32'(busy), 32'd0);

    // Short low glitch is rejected at the start-bit midpoint
    holdRx(1'b0, 30);
    checkEq("busyDuringGlitch", 32'(busy), 32'd1);
    holdRx(1'b1, 60);
    checkEq("busyAfterGlitch", 32'(busy), 32'd0);
    checkEq("dataBitsAfterGlitch", 32'(dataBits), 32'(lastGood));

    // Bad stop bit followed by a long break
    pushError();
    sendFrame(8'h3C, 1'b0, Cpb);
    holdRx(1'b0, 1000);
    checkEq("busyInBreak1", 32'(busy), 32'd1);
    holdRx(1'b0, 1000);
    checkEq("busyInBreak2", 32'(busy), 32'd1);
    checkEq("dataBitsAfterError", 32'(dataBits), 32'(lastGood));
    holdRx(1'b1, 5);
    checkEq("busyAfterBreak", 32'(busy), 32'd0);
    holdRx(1'b1, 50);

    // Back-to-back frames with a single stop bit
    pushValid(8'h00);
    pushValid(8'hFF);
    sendFrame(8'h00, 1'b1, Cpb);
    sendFrame(8'hFF, 1'b1, Cpb);
    holdRx(1'b1, 20);
    checkEq("dataBitsAfterBackToBack", 32'(dataBits), 32'hFF);

    // System reset in the middle of data bit 4 aborts the 0x55 frame
    partial = 8'h55;
    holdRx(1'b0, Cpb);
    for (int i = 0; i < 4; i++) holdRx(partial[i], Cpb);
    holdRx(partial[4], Cpb / 2);
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    lastGood = 8'h00;
    checkEq("busyAfterMidReset", 32'(busy), 32'd0);
    checkEq("dataBitsAfterMidReset", 32'(dataBits), 32'd0);
    holdRx(1'b1, 3 * Cpb);
    checkEq("busyIdleAfterReset", 32'(busy), 32'd0);
    pushValid(8'h81);
    sendFrame(8'h81, 1'b1, Cpb);
    holdRx(1'b1, 20);

    // Transmitter 3% slow
    pushValid(8'h5A);
    sendFrame(8'h5A, 1'b1, 107);
    holdRx(1'b1, 20);
    checkEq("busyAfterSlowFrame", 32'(busy), 32'd0);

    checkEq("pendingExpectations", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
